// File: rtl/cache_miss_ctrl_pkg.sv
// Shared definitions for the cache miss controller: geometry defaults and FSM encoding.
package cache_miss_ctrl_pkg;

    localparam int INDEX_DEF     = 3;
    localparam int CACHESIZE_DEF = 8;
    localparam int MEMBITS_DEF   = 5;
    localparam int TAGW_DEF      = MEMBITS_DEF - INDEX_DEF;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;
    localparam logic [1:0] ST_WTHRU = 2'd3;

endpackage

// File: rtl/cache_miss_ctrl_tag_store.sv
// Tag array plus valid vector for a direct-mapped cache: one compare port, one write port.
module cache_miss_ctrl_tag_store
    import cache_miss_ctrl_pkg::*;
#(
    parameter int INDEX     = INDEX_DEF,
    parameter int CACHESIZE = CACHESIZE_DEF,
    parameter int TAGW      = TAGW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [INDEX-1:0] cmp_idx_i,
    input  logic [TAGW-1:0]  cmp_tag_i,
    output logic             cmp_hit_o,
    input  logic             wr_en_i,
    input  logic [INDEX-1:0] wr_idx_i,
    input  logic [TAGW-1:0]  wr_tag_i
);

    logic [TAGW-1:0]      tag_q [CACHESIZE];
    logic [CACHESIZE-1:0] valid_q;

    // Install a tag and mark its line valid; reset invalidates every line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < CACHESIZE; i++) begin
                tag_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            tag_q[wr_idx_i]   <= wr_tag_i;
        end
    end

    // Hit means the indexed line is valid and holds the requested tag.
    always_comb begin
        cmp_hit_o = valid_q[cmp_idx_i] & (tag_q[cmp_idx_i] == cmp_tag_i);
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss controller in front of a direct-mapped, write-through, no-write-allocate data RAM.
// Resolves hits combinationally, fetches missing words over a req/ack handshake and
// presents a one-cycle refill pulse to the data RAM.
module cache_miss_ctrl
    import cache_miss_ctrl_pkg::*;
#(
    parameter int INDEX     = INDEX_DEF,
    parameter int CACHESIZE = CACHESIZE_DEF,
    parameter int MEMBITS   = MEMBITS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [MEMBITS-1:0] cpu_addr,
    input  logic [31:0]        cpu_wdata,
    output logic               cpu_ready,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_hit,
    output logic [INDEX-1:0]   dr_index,
    output logic [31:0]        dr_wdata,
    output logic               dr_write,
    output logic               dr_read,
    output logic               dr_match,
    output logic               fill_valid,
    output logic               fill_match,
    output logic [MEMBITS-1:0] fill_addr,
    output logic [31:0]        fill_data,
    output logic               mem_req,
    output logic               mem_we,
    output logic [MEMBITS-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic               mem_ack,
    input  logic [31:0]        mem_rdata
);

    localparam int TAGW = MEMBITS - INDEX;

    state_t             state_q, state_d;
    logic [MEMBITS-1:0] addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               hit_q, hit_d;
    logic [31:0]        fill_data_q, fill_data_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               ts_hit_s;
    logic               hit_s;
    logic               tag_we_s;

    cache_miss_ctrl_tag_store #(
        .INDEX     (INDEX),
        .CACHESIZE (CACHESIZE),
        .TAGW      (TAGW)
    ) u_tag_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmp_idx_i (cpu_addr[INDEX-1:0]),
        .cmp_tag_i (cpu_addr[MEMBITS-1:INDEX]),
        .cmp_hit_o (ts_hit_s),
        .wr_en_i   (tag_we_s),
        .wr_idx_i  (addr_q[INDEX-1:0]),
        .wr_tag_i  (addr_q[MEMBITS-1:INDEX])
    );

    assign hit_s     = cpu_req & ts_hit_s;
    assign cpu_rdata = rdata_q;
    assign fill_data = fill_data_q;

    // FSM next state, latched transaction context and all strobe outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        hit_d       = hit_q;
        fill_data_d = fill_data_q;
        rdata_d     = rdata_q;
        tag_we_s    = 1'b0;
        cpu_ready   = 1'b0;
        cpu_hit     = 1'b0;
        dr_index    = '0;
        dr_wdata    = 32'h0000_0000;
        dr_write    = 1'b0;
        dr_read     = 1'b0;
        dr_match    = 1'b0;
        fill_valid  = 1'b0;
        fill_match  = 1'b0;
        fill_addr   = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = 32'h0000_0000;

        case (state_q)
            ST_IDLE: begin
                dr_index = cpu_addr[INDEX-1:0];
                dr_wdata = cpu_wdata;
                if (cpu_req) begin
                    if (cpu_we) begin
                        // Write-through: RAM updated only when the line is resident.
                        dr_write = hit_s;
                        addr_d   = cpu_addr;
                        wdata_d  = cpu_wdata;
                        hit_d    = hit_s;
                        state_d  = ST_WTHRU;
                    end else if (hit_s) begin
                        dr_read   = 1'b1;
                        dr_match  = 1'b1;
                        cpu_ready = 1'b1;
                        cpu_hit   = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        // RAM read strobed without match so it holds its output.
                        dr_read = 1'b1;
                        addr_d  = cpu_addr;
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) begin
                    tag_we_s    = 1'b1;
                    fill_data_d = mem_rdata;
                    rdata_d     = mem_rdata;
                    state_d     = ST_FILL;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FILL: begin
                // Refill pulse; the CPU is not sampled here so no RAM write can collide.
                fill_valid = 1'b1;
                fill_match = 1'b0;
                fill_addr  = addr_q;
                cpu_ready  = 1'b1;
                cpu_hit    = 1'b0;
                state_d    = ST_IDLE;
            end
            ST_WTHRU: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ack) begin
                    cpu_ready = 1'b1;
                    cpu_hit   = hit_q;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WTHRU;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and transaction context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= 32'h0000_0000;
            hit_q       <= 1'b0;
            fill_data_q <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            hit_q       <= hit_d;
            fill_data_q <= fill_data_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: directed vectors push expectations into queues,
// a negedge monitor pops and compares whenever the DUT completes, fills or hits memory.
module tb_cache_miss_ctrl;

    localparam int INDEX   = 3;
    localparam int MEMBITS = 5;

    logic               clk;
    logic               rst_n;
    logic               cpu_req;
    logic               cpu_we;
    logic [MEMBITS-1:0] cpu_addr;
    logic [31:0]        cpu_wdata;
    logic               cpu_ready;
    logic [31:0]        cpu_rdata;
    logic               cpu_hit;
    logic [INDEX-1:0]   dr_index;
    logic [31:0]        dr_wdata;
    logic               dr_write;
    logic               dr_read;
    logic               dr_match;
    logic               fill_valid;
    logic               fill_match;
    logic [MEMBITS-1:0] fill_addr;
    logic [31:0]        fill_data;
    logic               mem_req;
    logic               mem_we;
    logic [MEMBITS-1:0] mem_addr;
    logic [31:0]        mem_wdata;
    logic               mem_ack;
    logic [31:0]        mem_rdata;

    cache_miss_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_hit    (cpu_hit),
        .dr_index   (dr_index),
        .dr_wdata   (dr_wdata),
        .dr_write   (dr_write),
        .dr_read    (dr_read),
        .dr_match   (dr_match),
        .fill_valid (fill_valid),
        .fill_match (fill_match),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               we;
        logic [MEMBITS-1:0] addr;
        logic [31:0]        wdata;
        int                 lat;
        logic [31:0]        mdata;
        bit                 tie;
        bit                 exp_hit;
        int                 exp_lat;
    } vec_t;

    typedef struct {
        logic        we;
        logic        hit;
        logic [31:0] rdata;
        int          lat;
    } sb_t;

    typedef struct {
        logic               we;
        logic [MEMBITS-1:0] addr;
        logic [31:0]        wdata;
    } mem_t;

    typedef struct {
        logic [MEMBITS-1:0] addr;
        logic [31:0]        data;
    } fill_t;

    vec_t  vecs[$];
    sb_t   sb_q[$];
    mem_t  mem_q[$];
    fill_t fill_q[$];

    int errors   = 0;
    int checks   = 0;
    int lat_cnt  = 0;
    bit end_req  = 1'b0;
    bit end_done = 1'b0;

    logic [149:0] outs_s;
    assign outs_s = {cpu_ready, cpu_rdata, cpu_hit, dr_index, dr_wdata, dr_write, dr_read,
                     dr_match, fill_valid, fill_match, fill_addr, fill_data, mem_req, mem_we,
                     mem_addr, mem_wdata};

    // Monitor: every comparison in the bench happens here, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            lat_cnt = 0;
            checks++;
            if (outs_s != '0) begin
                errors++;
                $display("FAIL reset_outputs got=%h required=0", outs_s);
            end
        end else begin
            if (cpu_req && lat_cnt == 0 && sb_q.size() > 0) begin
                checks++;
                if (dr_index != cpu_addr[INDEX-1:0] || mem_req != 1'b0) begin
                    errors++;
                    $display("FAIL req_cycle dr_index=%0d mem_req=%0d required dr_index=%0d mem_req=0",
                             dr_index, mem_req, cpu_addr[INDEX-1:0]);
                end
                if (cpu_we) begin
                    checks++;
                    if (dr_write != sb_q[0].hit || dr_wdata != cpu_wdata || dr_read != 1'b0) begin
                        errors++;
                        $display("FAIL store_ram dr_write=%0d dr_wdata=%h dr_read=%0d required %0d %h 0",
                                 dr_write, dr_wdata, dr_read, sb_q[0].hit, cpu_wdata);
                    end
                end else begin
                    checks++;
                    if (dr_read != 1'b1 || dr_match != sb_q[0].hit || dr_write != 1'b0) begin
                        errors++;
                        $display("FAIL load_ram dr_read=%0d dr_match=%0d dr_write=%0d required 1 %0d 0",
                                 dr_read, dr_match, dr_write, sb_q[0].hit);
                    end
                end
            end
            if (fill_valid) begin
                checks++;
                if (fill_q.size() == 0) begin
                    errors++;
                    $display("FAIL fill_unexpected addr=%h required no fill", fill_addr);
                end else begin
                    fill_t f;
                    f = fill_q.pop_front();
                    if (fill_addr != f.addr || fill_data != f.data || fill_match != 1'b0 || dr_write != 1'b0) begin
                        errors++;
                        $display("FAIL fill addr=%h data=%h match=%0d dr_write=%0d required %h %h 0 0",
                                 fill_addr, fill_data, fill_match, dr_write, f.addr, f.data);
                    end
                end
            end
            if (mem_req && mem_ack) begin
                checks++;
                if (mem_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_unexpected we=%0d addr=%h required no access", mem_we, mem_addr);
                end else begin
                    mem_t m;
                    m = mem_q.pop_front();
                    if (mem_we != m.we || mem_addr != m.addr || (m.we && mem_wdata != m.wdata)) begin
                        errors++;
                        $display("FAIL mem_access we=%0d addr=%h wdata=%h required %0d %h %h",
                                 mem_we, mem_addr, mem_wdata, m.we, m.addr, m.wdata);
                    end
                end
            end
            if (cpu_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL ready_unexpected hit=%0d required no completion", cpu_hit);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    if (cpu_hit != e.hit || lat_cnt != e.lat ||
                        (!e.we && !e.hit && cpu_rdata != e.rdata)) begin
                        errors++;
                        $display("FAIL completion hit=%0d lat=%0d rdata=%h required %0d %0d %h",
                                 cpu_hit, lat_cnt, cpu_rdata, e.hit, e.lat, e.rdata);
                    end
                end
                lat_cnt = 0;
            end else if (cpu_req) begin
                lat_cnt++;
            end
        end
        if (end_req && !end_done) begin
            checks++;
            if (sb_q.size() != 0 || mem_q.size() != 0 || fill_q.size() != 0) begin
                errors++;
                $display("FAIL leftover sb=%0d mem=%0d fill=%0d required 0 0 0",
                         sb_q.size(), mem_q.size(), fill_q.size());
            end
            end_done = 1'b1;
        end
    end

    task automatic add_vec(input logic we, input logic [MEMBITS-1:0] addr, input logic [31:0] wdata,
                           input int lat, input logic [31:0] mdata, input bit tie,
                           input bit exp_hit, input int exp_lat);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.lat = lat; v.mdata = mdata;
        v.tie = tie; v.exp_hit = exp_hit; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endtask

    // Drives one CPU request and acts as the memory: ack after 'lat' requesting cycles.
    task automatic transact(input vec_t v);
        int waited = 0;
        int cyc    = 0;
        bit done   = 1'b0;
        @(posedge clk); #1;
        cpu_req   = 1'b1;
        cpu_we    = v.we;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        while (!done) begin
            mem_rdata = v.mdata;
            if (v.tie) begin
                mem_ack = 1'b1;
            end else if (mem_req) begin
                mem_ack = (waited == v.lat);
                waited++;
            end else begin
                mem_ack = 1'b0;
            end
            @(negedge clk);
            if (cpu_ready) begin
                done = 1'b1;
            end else begin
                cyc++;
                if (cyc > 64) begin
                    $display("FAIL timeout addr=%h no cpu_ready within 64 cycles", v.addr);
                    $fatal(1, "timeout");
                end
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        mem_ack = 1'b0;
    endtask

    // Starts a load miss on 0x0D and pulls reset while the fetch is outstanding.
    task automatic reset_mid_fetch();
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 5'h0D;
        mem_ack  = 1'b0;
        @(posedge clk); #1;
        if (!mem_req) begin
            $display("FAIL rst_setup mem_req=0 required 1");
            $fatal(1, "no fetch before reset");
        end
        rst_n    = 1'b0;
        cpu_req  = 1'b0;
        cpu_addr = 5'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 5'h00;
        cpu_wdata = 32'h0000_0000;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0000_0000;

        //      we    addr   wdata          lat  mdata          tie  hit  latency
        add_vec(1'b0, 5'h05, 32'h0000_0000, 2,   32'hDEAD_BEEF, 0,   0,   4);
        add_vec(1'b0, 5'h05, 32'h0000_0000, 0,   32'h0000_0000, 0,   1,   0);
        add_vec(1'b0, 5'h0D, 32'h0000_0000, 1,   32'hCAFE_F00D, 0,   0,   3);
        add_vec(1'b0, 5'h05, 32'h0000_0000, 0,   32'h0BAD_C0DE, 0,   0,   2);
        add_vec(1'b0, 5'h0D, 32'h0000_0000, 0,   32'h1111_1111, 0,   0,   2);
        add_vec(1'b1, 5'h0D, 32'h1234_5678, 1,   32'h0000_0000, 0,   1,   2);
        add_vec(1'b1, 5'h15, 32'hA5A5_A5A5, 0,   32'h0000_0000, 0,   0,   1);
        add_vec(1'b0, 5'h0D, 32'h0000_0000, 0,   32'h0000_0000, 0,   1,   0);
        add_vec(1'b0, 5'h15, 32'h0000_0000, 0,   32'h55AA_55AA, 1,   0,   2);
        add_vec(1'b1, 5'h02, 32'h0000_BEEF, 0,   32'h0000_0000, 1,   0,   1);
        add_vec(1'b0, 5'h15, 32'h0000_0000, 0,   32'h0000_0000, 0,   1,   0);
        add_vec(1'b0, 5'h05, 32'h0000_0000, 3,   32'h2468_ACE0, 0,   0,   5);
        add_vec(1'b0, 5'h05, 32'h0000_0000, 1,   32'h7777_7777, 0,   0,   3);
        add_vec(1'b0, 5'h05, 32'h0000_0000, 0,   32'h0000_0000, 0,   1,   0);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            sb_t   e;
            mem_t  m;
            fill_t f;
            if (i == 12) begin
                reset_mid_fetch();
            end
            e.we    = vecs[i].we;
            e.hit   = vecs[i].exp_hit;
            e.rdata = vecs[i].mdata;
            e.lat   = vecs[i].exp_lat;
            sb_q.push_back(e);
            if (vecs[i].we || !vecs[i].exp_hit) begin
                m.we    = vecs[i].we;
                m.addr  = vecs[i].addr;
                m.wdata = vecs[i].wdata;
                mem_q.push_back(m);
            end
            if (!vecs[i].we && !vecs[i].exp_hit) begin
                f.addr = vecs[i].addr;
                f.data = vecs[i].mdata;
                fill_q.push_back(f);
            end
            transact(vecs[i]);
        end

        repeat (2) @(posedge clk);
        end_req = 1'b1;
        for (int k = 0; k < 10 && !end_done; k++) begin
            @(posedge clk);
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
